// File: rtl/bus_sequencer_pkg.sv
// Shared definitions for the single-bus control sequencer: widths, bus-source
// indices, opcode boundaries, step codes, state encoding and opcode class flags.
package bus_sequencer_pkg;

    localparam int unsigned NUM_SRC = 24;
    localparam int unsigned NUM_REG = 16;
    localparam int unsigned OPW     = 5;
    localparam int unsigned REGW    = 4;
    localparam int unsigned SRCW    = 5;
    localparam int unsigned STEPW   = 4;

    // Bus-source bit positions in bus_sel (R0..R15 occupy 0-15)
    localparam logic [SRCW-1:0] SRC_MDR  = SRCW'(16);
    localparam logic [SRCW-1:0] SRC_ZHI  = SRCW'(19);
    localparam logic [SRCW-1:0] SRC_ZLO  = SRCW'(20);
    localparam logic [SRCW-1:0] SRC_PC   = SRCW'(21);
    localparam logic [SRCW-1:0] SRC_C    = SRCW'(23);

    localparam logic [OPW-1:0] OP_RFMT_LAST = OPW'(11);
    localparam logic [OPW-1:0] OP_ADDI      = OPW'(12);
    localparam logic [OPW-1:0] OP_ORI       = OPW'(14);
    localparam logic [OPW-1:0] OP_MUL       = OPW'(15);
    localparam logic [OPW-1:0] OP_DIV       = OPW'(16);
    localparam logic [OPW-1:0] OP_NEG       = OPW'(17);
    localparam logic [OPW-1:0] OP_NOT       = OPW'(18);
    localparam logic [OPW-1:0] OP_NOP       = OPW'(26);
    localparam logic [OPW-1:0] OP_HALT      = OPW'(27);

    localparam logic [STEPW-1:0] STEP_IDLE = STEPW'(15);
    localparam logic [STEPW-1:0] STEP_WAIT = STEPW'(8);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED
    } state_t;

    typedef struct packed {
        logic is_rfmt;
        logic is_ifmt;
        logic is_muldiv;
        logic is_unary;
        logic is_nop;
        logic is_halt;
        logic is_undef;
    } op_class_t;

    // One-hot bus select for a source index
    function automatic logic [NUM_SRC-1:0] src_sel(input logic [SRCW-1:0] idx);
        return NUM_SRC'(1) << idx;
    endfunction

endpackage

// File: rtl/bus_sequencer_ctrl_opcode_decode.sv
// Classifies the instruction opcode into the execution classes that steer T3-T6.
module bus_sequencer_ctrl_opcode_decode
    import bus_sequencer_pkg::*;
(
    input  logic [OPW-1:0] i_op,
    output op_class_t      o_class
);

    always_comb begin
        o_class = '0;
        if (i_op <= OP_RFMT_LAST)
            o_class.is_rfmt = 1'b1;
        else if (i_op >= OP_ADDI && i_op <= OP_ORI)
            o_class.is_ifmt = 1'b1;
        else if (i_op == OP_MUL || i_op == OP_DIV)
            o_class.is_muldiv = 1'b1;
        else if (i_op == OP_NEG || i_op == OP_NOT)
            o_class.is_unary = 1'b1;
        else if (i_op == OP_NOP)
            o_class.is_nop = 1'b1;
        else if (i_op == OP_HALT)
            o_class.is_halt = 1'b1;
        else
            o_class.is_undef = 1'b1;
    end

endmodule

// File: rtl/bus_sequencer.sv
// Hardwired T-step control unit for the single-bus datapath: fetch (with memory
// wait), decode and execute, driving bus-source selects and register load enables.
module bus_sequencer
    import bus_sequencer_pkg::*;
(
    input  logic               clock,
    input  logic               clear,
    input  logic               run,
    input  logic [31:0]        ir,
    input  logic               mem_ready,
    output logic [NUM_SRC-1:0] bus_sel,
    output logic [NUM_REG-1:0] reg_in,
    output logic               MARin,
    output logic               MDRin,
    output logic               IRin,
    output logic               PCin,
    output logic               IncPC,
    output logic               Yin,
    output logic               Zin,
    output logic               HIin,
    output logic               LOin,
    output logic               Read,
    output logic [OPW-1:0]     alu_op,
    output logic [STEPW-1:0]   step,
    output logic               halted,
    output logic               illegal
);

    state_t          r_state;
    state_t          w_next;
    logic [OPW-1:0]  w_op;
    logic [REGW-1:0] w_ra;
    logic [REGW-1:0] w_rb;
    logic [REGW-1:0] w_rc;
    op_class_t       w_class;
    logic            w_unused_ir;

    assign w_op        = ir[31:27];
    assign w_ra        = ir[26:23];
    assign w_rb        = ir[22:19];
    assign w_rc        = ir[18:15];
    assign w_unused_ir = ^ir[14:0];

    bus_sequencer_ctrl_opcode_decode u_decode (
        .i_op    (w_op),
        .o_class (w_class)
    );

    always_ff @(posedge clock) begin
        if (!clear)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state and control-line decode; MDRin follows mem_ready during the read
    always_comb begin
        w_next  = r_state;
        bus_sel = '0;
        reg_in  = '0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        PCin    = 1'b0;
        IncPC   = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        HIin    = 1'b0;
        LOin    = 1'b0;
        Read    = 1'b0;
        alu_op  = '0;
        step    = STEP_IDLE;
        halted  = 1'b0;
        illegal = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run)
                    w_next = S_T0;
            end
            S_T0: begin
                step    = STEPW'(0);
                bus_sel = src_sel(SRC_PC);
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                w_next  = S_T1;
            end
            S_T1: begin
                step    = STEPW'(1);
                bus_sel = src_sel(SRC_ZLO);
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = mem_ready;
                w_next  = mem_ready ? S_T2 : S_T1W;
            end
            S_T1W: begin
                step   = STEP_WAIT;
                Read   = 1'b1;
                MDRin  = mem_ready;
                if (mem_ready)
                    w_next = S_T2;
            end
            S_T2: begin
                step    = STEPW'(2);
                bus_sel = src_sel(SRC_MDR);
                IRin    = 1'b1;
                w_next  = S_T3;
            end
            S_T3: begin
                step = STEPW'(3);
                if (w_class.is_rfmt || w_class.is_ifmt || w_class.is_muldiv) begin
                    bus_sel = src_sel(SRCW'(w_rb));
                    Yin     = 1'b1;
                    w_next  = S_T4;
                end else if (w_class.is_unary) begin
                    w_next = S_T4;
                end else if (w_class.is_halt) begin
                    w_next = S_HALTED;
                end else if (w_class.is_nop || w_class.is_undef) begin
                    illegal = w_class.is_undef;
                    w_next  = run ? S_T0 : S_IDLE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_T4: begin
                step   = STEPW'(4);
                Zin    = 1'b1;
                alu_op = w_op;
                if (w_class.is_ifmt)
                    bus_sel = src_sel(SRC_C);
                else if (w_class.is_unary)
                    bus_sel = src_sel(SRCW'(w_rb));
                else
                    bus_sel = src_sel(SRCW'(w_rc));
                w_next = S_T5;
            end
            S_T5: begin
                step    = STEPW'(5);
                bus_sel = src_sel(SRC_ZLO);
                if (w_class.is_muldiv) begin
                    LOin   = 1'b1;
                    w_next = S_T6;
                end else begin
                    reg_in = NUM_REG'(1) << w_ra;
                    w_next = run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                step    = STEPW'(6);
                bus_sel = src_sel(SRC_ZHI);
                HIin    = 1'b1;
                w_next  = run ? S_T0 : S_IDLE;
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
